uart_tx_fifo: RTL and testbench

//  Transmit half of the UART: buffers bytes from the core in a small FIFO and serialises them on data_tx.

---
 rtl/uart_tx_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO.
// A frame is a start bit, 8 data bits LSB first, an optional parity bit and STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 1_000_000,
    parameter int BAUD_BASE  = 62_500,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clkI,
    input  logic                          reset,
    input  logic [1:0]                    baud_rate,
    input  logic [1:0]                    parity_type,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          data_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int DIV0 = CLK_FREQ / BAUD_BASE;
    localparam int DIV1 = CLK_FREQ / (BAUD_BASE * 2);
    localparam int DIV2 = CLK_FREQ / (BAUD_BASE * 4);
    localparam int DIV3 = CLK_FREQ / (BAUD_BASE * 8);
    localparam int CW   = (DIV0 > 1) ? $clog2(DIV0) : 1;
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    // state  | meaning
    // IDLE   | line high, pop next byte when FIFO non-empty
    // START  | start bit (low)
    // DATA   | 8 data bits, LSB first
    // PARITY | parity bit, only when parity enabled
    // STOP   | STOP_BITS stop bits (high), tx_done on exit
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [CW-1:0] r_div_m1;
    logic          r_par_en;
    logic          r_par_bit;
    logic          r_data_tx;
    logic          r_tx_done;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic [CW-1:0] w_div_m1_nxt;
    logic          w_par_en_nxt;
    logic          w_par_bit_nxt;
    logic          w_data_tx_nxt;
    logic          w_tx_done_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic [7:0]    w_rd_data;
    logic [CW-1:0] w_div_m1_sel;

    assign tx_ready   = (r_count != FULL_CNT);
    assign w_push     = tx_valid && tx_ready;
    assign w_rd_data  = r_mem[r_rd_ptr];
    assign w_bit_end  = (r_cnt == r_div_m1);
    assign data_tx    = r_data_tx;
    assign tx_busy    = (r_state != S_IDLE);
    assign tx_done    = r_tx_done;
    assign fifo_count = r_count;

    always_comb begin
        case (baud_rate)
            2'b00:   w_div_m1_sel = CW'(DIV0 - 1);
            2'b01:   w_div_m1_sel = CW'(DIV1 - 1);
            2'b10:   w_div_m1_sel = CW'(DIV2 - 1);
            default: w_div_m1_sel = CW'(DIV3 - 1);
        endcase
    end

    always_ff @(posedge clkI) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clkI) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

    always_ff @(posedge clkI) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_div_m1  <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_data_tx <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_div_m1  <= w_div_m1_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_data_tx <= w_data_tx_nxt;
            r_tx_done <= w_tx_done_nxt;
        end
    end

    // data_tx is registered, so each transition loads the level of the state being entered
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_div_m1_nxt  = r_div_m1;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_data_tx_nxt = r_data_tx;
        w_tx_done_nxt = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_data_tx_nxt = 1'b1;
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_rd_data;
                    w_div_m1_nxt  = w_div_m1_sel;
                    w_par_en_nxt  = parity_type[0] ^ parity_type[1];
                    w_par_bit_nxt = (parity_type == 2'b01) ? ~^w_rd_data : ^w_rd_data;
                    w_cnt_nxt     = '0;
                    w_data_tx_nxt = 1'b0;
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_nxt     = '0;
                    w_data_tx_nxt = r_shift[0];
                    w_state_nxt   = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        w_bit_nxt = '0;
                        if (r_par_en) begin
                            w_data_tx_nxt = r_par_bit;
                            w_state_nxt   = S_PARITY;
                        end else begin
                            w_data_tx_nxt = 1'b1;
                            w_state_nxt   = S_STOP;
                        end
                    end else begin
                        w_bit_nxt     = r_bit + 3'd1;
                        w_data_tx_nxt = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_nxt     = '0;
                    w_data_tx_nxt = 1'b1;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'(STOP_BITS - 1)) begin
                        w_tx_done_nxt = 1'b1;
                        w_data_tx_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_data_tx_nxt = 1'b1;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-waveform reference model checked every cycle,
// directed scenarios with literal expectations, a line decoder, then random traffic.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUD_BASE  = 62_500;
    localparam int FIFO_DEPTH = 4;
    localparam int STOP_BITS  = 1;

    logic       clkI = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] baud_rate = 2'b00;
    logic [1:0] parity_type = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       data_tx;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;

    always #5 clkI = ~clkI;

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD_BASE(BAUD_BASE),
        .FIFO_DEPTH(FIFO_DEPTH), .STOP_BITS(STOP_BITS)
    ) dut (
        .clkI(clkI), .reset(reset), .baud_rate(baud_rate), .parity_type(parity_type),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .data_tx(data_tx),
        .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
        end
    endtask

    function automatic int div_of(input logic [1:0] b);
        return CLK_FREQ / (BAUD_BASE << b);
    endfunction

    // Reference model: FIFO as a queue, the frame as the list of line levels per cycle
    byte unsigned m_q[$];
    bit           m_wave[$];
    bit           m_in_frame = 0;
    bit           m_tx = 1;
    bit           m_done = 0;
    bit           m_valid = 0;
    bit           m_push;

    function automatic void build_frame(input byte unsigned d, input logic [1:0] b, input logic [1:0] p);
        int dv = div_of(b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (p == 2'b01) bits.push_back(~^d);
        else if (p == 2'b10) bits.push_back(^d);
        for (int i = 0; i < STOP_BITS; i++) bits.push_back(1'b1);
        m_wave.delete();
        foreach (bits[k]) for (int r = 0; r < dv; r++) m_wave.push_back(bits[k]);
    endfunction

    always @(posedge clkI) begin
        if (reset) begin
            m_q.delete();
            m_wave.delete();
            m_in_frame = 0;
            m_tx = 1;
            m_done = 0;
            m_valid = 1;
        end else begin
            m_push = tx_valid && (m_q.size() < FIFO_DEPTH);
            m_done = 0;
            if (m_in_frame) begin
                if (m_wave.size() != 0) m_tx = m_wave.pop_front();
                else begin
                    m_in_frame = 0;
                    m_done = 1;
                    m_tx = 1;
                end
            end else if (m_q.size() != 0) begin
                build_frame(m_q.pop_front(), baud_rate, parity_type);
                m_tx = m_wave.pop_front();
                m_in_frame = 1;
            end else begin
                m_tx = 1;
            end
            if (m_push) m_q.push_back(tx_data);
        end
    end

    always @(negedge clkI) begin
        if (m_valid) begin
            chk("data_tx", data_tx, m_tx);
            chk("tx_busy", tx_busy, m_in_frame);
            chk("tx_done", tx_done, m_done);
            chk("fifo_count", fifo_count, m_q.size());
            chk("tx_ready", tx_ready, m_q.size() < FIFO_DEPTH);
        end
    end

    // Loopback receiver: samples mid-bit with the config seen at the start bit
    byte unsigned rx_log[$];
    bit           dec_en = 0;
    bit           dec_act = 0;
    bit           dec_prev = 1;
    bit           dec_penab;
    int           dec_cnt, dec_div, dec_pos;
    logic [1:0]   dec_par;
    logic [7:0]   dec_byte;

    always @(negedge clkI) begin
        if (!dec_en) dec_act = 0;
        else if (!dec_act) begin
            if (dec_prev && !data_tx) begin
                dec_act = 1;
                dec_cnt = 0;
                dec_div = div_of(baud_rate);
                dec_par = parity_type;
                dec_byte = 8'h00;
            end
        end else begin
            dec_cnt++;
            dec_pos = dec_cnt / dec_div;
            dec_penab = (dec_par == 2'b01) || (dec_par == 2'b10);
            if (dec_cnt % dec_div == dec_div / 2) begin
                if (dec_pos == 0) chk("rx_start", data_tx, 0);
                else if (dec_pos >= 1 && dec_pos <= 8) dec_byte[3'(dec_pos - 1)] = data_tx;
                else if (dec_pos == 9 && dec_penab)
                    chk("rx_parity", data_tx, (dec_par == 2'b10) ? ^dec_byte : ~^dec_byte);
                else if (dec_pos == 9 + int'(dec_penab)) begin
                    chk("rx_stop", data_tx, 1);
                    rx_log.push_back(dec_byte);
                    dec_act = 0;
                end
            end
        end
        dec_prev = data_tx;
    end

    task automatic wait_idle();
        int n = 0;
        while (n < 2000 && (tx_busy || fifo_count != 0)) begin
            @(negedge clkI);
            n++;
        end
        chk("idle_reached", n < 2000, 1);
        repeat (3) @(negedge clkI);
    endtask

    task automatic send_measure(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                                input int sidx, input int chg_at, input logic [1:0] chg_val,
                                output int len, output logic smp);
        int  c = 0;
        bit  started = 0;
        bit  fin = 0;
        baud_rate = b;
        parity_type = p;
        tx_data = d;
        tx_valid = 1;
        @(negedge clkI);
        tx_valid = 0;
        for (int i = 0; i < 10 && !started; i++) begin
            if (data_tx == 1'b0) started = 1;
            else @(negedge clkI);
        end
        chk("start_seen", started, 1);
        len = -1;
        smp = 1'bx;
        while (started && !fin && c < 400) begin
            @(negedge clkI);
            c++;
            if (c == sidx) smp = data_tx;
            if (c == chg_at) baud_rate = chg_val;
            if (tx_done) begin
                len = c;
                fin = 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         len, k, cyc, a5_cyc;
        logic       smp;
        bit         w, saw;
        byte unsigned exp_rx[14];
        exp_rx = '{8'h55, 8'h07, 8'h07, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
                   8'h81, 8'h18, 8'h00, 8'hFF, 8'h5A};

        repeat (3) @(negedge clkI);
        chk("rst_data_tx", data_tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", tx_ready, 1);
        reset = 0;
        dec_en = 1;
        repeat (2) @(negedge clkI);

        // 1: 0x55 at DIV=2, no parity
        baud_rate = 2'b11; parity_type = 2'b00; tx_data = 8'h55; tx_valid = 1;
        @(negedge clkI);
        tx_valid = 0;
        chk("t1_line_high_after_push", data_tx, 1);
        @(negedge clkI);
        for (int i = 0; i < 20; i++) begin
            chk("t1_bit", data_tx, (i / 2) % 2);
            @(negedge clkI);
        end
        chk("t1_done", tx_done, 1);
        chk("t1_line_idle", data_tx, 1);
        chk("t1_not_busy", tx_busy, 0);
        wait_idle();

        // 2: parity even then odd on 0x07 at DIV=4
        send_measure(8'h07, 2'b10, 2'b10, 37, -1, 2'b00, len, smp);
        chk("t2_even_len", len, 44);
        chk("t2_even_bit", smp, 1);
        wait_idle();
        send_measure(8'h07, 2'b10, 2'b01, 37, -1, 2'b00, len, smp);
        chk("t2_odd_len", len, 44);
        chk("t2_odd_bit", smp, 0);
        wait_idle();

        // 3: tx_valid held with 0xA0..0xA5 at DIV=16
        baud_rate = 2'b00; parity_type = 2'b00;
        k = 0; cyc = 0; a5_cyc = -1;
        tx_valid = 1; tx_data = 8'hA0;
        while (k < 6 && cyc < 1000) begin
            w = tx_ready;
            @(negedge clkI);
            cyc++;
            if (w) begin
                if (k == 5) a5_cyc = cyc;
                k++;
                tx_data = 8'hA0 + 8'(k);
            end
            if (cyc == 5) begin
                chk("t3_count_full", fifo_count, 4);
                chk("t3_ready_low", tx_ready, 0);
            end
        end
        tx_valid = 0;
        chk("t3_a5_accept_edge", a5_cyc, 164);
        wait_idle();

        // 4: reset during DATA of 0x3C with two bytes queued
        dec_en = 0;
        baud_rate = 2'b11; parity_type = 2'b00;
        tx_valid = 1; tx_data = 8'h3C;
        @(negedge clkI); tx_data = 8'h11;
        @(negedge clkI); tx_data = 8'h22;
        @(negedge clkI); tx_valid = 0;
        repeat (2) @(negedge clkI);
        chk("t4_queued", fifo_count, 2);
        chk("t4_busy", tx_busy, 1);
        reset = 1;
        @(negedge clkI);
        chk("t4_line_high", data_tx, 1);
        chk("t4_count_zero", fifo_count, 0);
        chk("t4_not_busy", tx_busy, 0);
        reset = 0;
        saw = 0;
        repeat (40) begin
            @(negedge clkI);
            if (tx_done || !data_tx || tx_busy) saw = 1;
        end
        chk("t4_quiet", saw, 0);
        dec_en = 1;
        repeat (2) @(negedge clkI);

        // 5: baud change 11->00 mid-frame
        send_measure(8'h81, 2'b11, 2'b00, -1, 5, 2'b00, len, smp);
        chk("t5_first_len", len, 20);
        wait_idle();
        send_measure(8'h18, baud_rate, 2'b00, -1, -1, 2'b00, len, smp);
        chk("t5_second_len", len, 160);
        wait_idle();

        // 6: loopback with odd parity at DIV=8
        baud_rate = 2'b01; parity_type = 2'b01;
        tx_valid = 1; tx_data = 8'h00;
        @(negedge clkI); tx_data = 8'hFF;
        @(negedge clkI); tx_data = 8'h5A;
        @(negedge clkI); tx_valid = 0;
        wait_idle();

        chk("rx_count", rx_log.size(), 14);
        for (int i = 0; i < 14 && i < rx_log.size(); i++) chk("rx_byte", rx_log[i], exp_rx[i]);
        dec_en = 0;

        // random traffic, config changes at any time, occasional reset
        for (int n = 0; n < 4000; n++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data = 8'($urandom);
            if ($urandom_range(0, 60) == 0) baud_rate = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 40) == 0) parity_type = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 700) == 0);
            @(negedge clkI);
        end
        reset = 0;
        tx_valid = 0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
